// File: rtl/mem_wb_if.sv
// Memory-stage to writeback-stage handshake bundle.
// The memory stage (master) presents a completed result and raises memory_done;
// the writeback stage (slave) acknowledges with mem_wb_pipeline_valid.
interface mem_wb_if #(
    parameter int addr_width = 64
);
    logic                  memory_done;
    logic [63:0]           loaded_data_in;
    logic [63:0]           alu_data;
    logic [addr_width-1:0] pc_plus4;
    logic [4:0]            dest_reg;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  jump_link;
    logic [2:0]            data_size;
    logic                  load_unsigned;
    logic                  mem_wb_pipeline_valid;

    // Memory stage side: drives the result, watches the acknowledge.
    modport master (
        output memory_done,
        output loaded_data_in,
        output alu_data,
        output pc_plus4,
        output dest_reg,
        output reg_write,
        output mem_to_reg,
        output jump_link,
        output data_size,
        output load_unsigned,
        input  mem_wb_pipeline_valid
    );

    // Writeback stage side: samples the result, drives the acknowledge.
    modport slave (
        input  memory_done,
        input  loaded_data_in,
        input  alu_data,
        input  pc_plus4,
        input  dest_reg,
        input  reg_write,
        input  mem_to_reg,
        input  jump_link,
        input  data_size,
        input  load_unsigned,
        output mem_wb_pipeline_valid
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Captures one memory-stage result per four-phase handshake, extracts and
// extends load data, issues a single register-file write strobe, exposes the
// last written value for forwarding and counts retired instructions.
module mem_wb_stage #(
    parameter int addr_width = 64
) (
    input  logic        clk,
    input  logic        reset,
    mem_wb_if.slave     mem_if,
    output logic        rf_write_enable,
    output logic [4:0]  rf_write_addr,
    output logic [63:0] rf_write_data,
    output logic        fwd_valid,
    output logic [4:0]  fwd_reg,
    output logic [63:0] fwd_data,
    output logic [63:0] retired_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  we_q, we_d;
    logic [4:0]            addr_q, addr_d;
    logic [63:0]           data_q, data_d;
    logic                  fwd_valid_q, fwd_valid_d;
    logic [63:0]           retired_q, retired_d;

    logic [addr_width-1:0] pc_link;
    logic [2:0]            byte_offset;
    logic [63:0]           load_shift;
    logic [63:0]           load_ext;
    logic [63:0]           wb_value;
    logic                  writes_rf;

    assign pc_link = mem_if.pc_plus4;

    // Align the byte offset to the access size, shift the doubleword down and extend it.
    always_comb begin
        byte_offset = 3'd0;
        load_shift  = '0;
        load_ext    = '0;
        case (mem_if.data_size)
            3'd0:    byte_offset = mem_if.alu_data[2:0];
            3'd1:    byte_offset = {mem_if.alu_data[2:1], 1'b0};
            3'd2:    byte_offset = {mem_if.alu_data[2], 2'b00};
            default: byte_offset = 3'd0;
        endcase
        load_shift = mem_if.loaded_data_in >> {byte_offset, 3'b000};
        case (mem_if.data_size)
            3'd0: begin
                if (mem_if.load_unsigned) load_ext = {56'd0, load_shift[7:0]};
                else                      load_ext = {{56{load_shift[7]}}, load_shift[7:0]};
            end
            3'd1: begin
                if (mem_if.load_unsigned) load_ext = {48'd0, load_shift[15:0]};
                else                      load_ext = {{48{load_shift[15]}}, load_shift[15:0]};
            end
            3'd2: begin
                if (mem_if.load_unsigned) load_ext = {32'd0, load_shift[31:0]};
                else                      load_ext = {{32{load_shift[31]}}, load_shift[31:0]};
            end
            default: load_ext = load_shift;
        endcase
    end

    // Pick the writeback source: link value first, then load data, else the ALU result.
    always_comb begin
        wb_value  = mem_if.alu_data;
        writes_rf = mem_if.reg_write && (mem_if.dest_reg != 5'd0);
        if (mem_if.jump_link) begin
            wb_value = 64'(pc_link);
        end else if (mem_if.mem_to_reg) begin
            wb_value = load_ext;
        end
    end

    // Handshake sequencing: capture once in IDLE, hold until memory_done drops.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        fwd_valid_d = fwd_valid_q;
        retired_d   = retired_q;
        case (state_q)
            IDLE: begin
                if (mem_if.memory_done) begin
                    state_d     = HOLD;
                    valid_d     = 1'b1;
                    we_d        = writes_rf;
                    addr_d      = mem_if.dest_reg;
                    data_d      = wb_value;
                    fwd_valid_d = writes_rf;
                    retired_d   = retired_q + 64'd1;
                end
            end
            HOLD: begin
                if (!mem_if.memory_done) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; an asserted reset discards any held result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 5'd0;
            data_q      <= 64'd0;
            fwd_valid_q <= 1'b0;
            retired_q   <= 64'd0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            fwd_valid_q <= fwd_valid_d;
            retired_q   <= retired_d;
        end
    end

    assign mem_if.mem_wb_pipeline_valid = valid_q;
    assign rf_write_enable              = we_q;
    assign rf_write_addr                = addr_q;
    assign rf_write_data                = data_q;
    assign fwd_valid                    = fwd_valid_q;
    assign fwd_reg                      = addr_q;
    assign fwd_data                     = data_q;
    assign retired_count                = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: fixed vector table, reset and
// handshake corner sequences, then randomized transactions against a model.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [63:0] rf_write_data;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [63:0] fwd_data;
    logic [63:0] retired_count;

    int          checks;
    int          errors;
    logic [63:0] exp_retired;
    logic        exp_fwd_valid;
    logic [4:0]  exp_fwd_reg;
    logic [63:0] exp_fwd_data;

    typedef struct {
        logic [63:0] loaded;
        logic [63:0] alu;
        logic [63:0] pc;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_to_reg;
        logic        jump_link;
        logic [2:0]  data_size;
        logic        load_unsigned;
        logic [63:0] exp_data;
        logic        exp_we;
    } vec_t;

    mem_wb_if #(.addr_width(64)) bus ();

    mem_wb_stage #(.addr_width(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_if          (bus),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .fwd_valid       (fwd_valid),
        .fwd_reg         (fwd_reg),
        .fwd_data        (fwd_data),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Writeback value from the architectural rules: aligned offset, mask, extend.
    function automatic logic [63:0] ref_wb(input vec_t v);
        int          nbytes;
        int          off;
        logic [63:0] mask;
        logic [63:0] raw;
        if (v.jump_link) return v.pc;
        if (!v.mem_to_reg) return v.alu;
        nbytes = (v.data_size >= 3'd3) ? 8 : (1 << v.data_size);
        off    = (int'(v.alu[2:0]) / nbytes) * nbytes;
        mask   = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
        raw    = (v.loaded >> (8 * off)) & mask;
        if (!v.load_unsigned && raw[8 * nbytes - 1]) raw = raw | ~mask;
        return raw;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
        end
    endtask

    task automatic drive_inputs(input vec_t v);
        bus.loaded_data_in = v.loaded;
        bus.alu_data       = v.alu;
        bus.pc_plus4       = v.pc;
        bus.dest_reg       = v.dest;
        bus.reg_write      = v.reg_write;
        bus.mem_to_reg     = v.mem_to_reg;
        bus.jump_link      = v.jump_link;
        bus.data_size      = v.data_size;
        bus.load_unsigned  = v.load_unsigned;
    endtask

    task automatic scramble_inputs();
        bus.loaded_data_in = {$urandom, $urandom};
        bus.alu_data       = {$urandom, $urandom};
        bus.pc_plus4       = {$urandom, $urandom};
        bus.dest_reg       = 5'($urandom);
        bus.reg_write      = 1'($urandom);
        bus.mem_to_reg     = 1'($urandom);
        bus.jump_link      = 1'($urandom);
        bus.data_size      = 3'($urandom);
        bus.load_unsigned  = 1'($urandom);
    endtask

    task automatic check_forwarding(input string tag);
        check_output({tag, " fwd_valid"}, 64'(fwd_valid), 64'(exp_fwd_valid));
        if (exp_fwd_valid) begin
            check_output({tag, " fwd_reg"}, 64'(fwd_reg), 64'(exp_fwd_reg));
            check_output({tag, " fwd_data"}, fwd_data, exp_fwd_data);
        end
    endtask

    // One full handshake; memory_done stays high for hold_extra edges after capture.
    task automatic apply_stimulus(input vec_t v, input int hold_extra, input string tag);
        drive_inputs(v);
        bus.memory_done = 1'b1;
        @(posedge clk); #1;
        exp_retired = exp_retired + 64'd1;
        exp_fwd_valid = v.exp_we;
        if (v.exp_we) begin
            exp_fwd_reg  = v.dest;
            exp_fwd_data = v.exp_data;
        end
        check_output({tag, " valid"}, 64'(bus.mem_wb_pipeline_valid), 64'd1);
        check_output({tag, " we"}, 64'(rf_write_enable), 64'(v.exp_we));
        if (v.exp_we) begin
            check_output({tag, " addr"}, 64'(rf_write_addr), 64'(v.dest));
            check_output({tag, " data"}, rf_write_data, v.exp_data);
        end
        check_output({tag, " retired"}, retired_count, exp_retired);
        check_forwarding(tag);
        scramble_inputs();
        for (int i = 0; i < hold_extra; i++) begin
            @(posedge clk); #1;
            check_output({tag, " hold valid"}, 64'(bus.mem_wb_pipeline_valid), 64'd1);
            check_output({tag, " hold we"}, 64'(rf_write_enable), 64'd0);
            check_output({tag, " hold retired"}, retired_count, exp_retired);
            check_forwarding({tag, " hold"});
        end
        bus.memory_done = 1'b0;
        @(posedge clk); #1;
        check_output({tag, " release valid"}, 64'(bus.mem_wb_pipeline_valid), 64'd0);
        check_output({tag, " release we"}, 64'(rf_write_enable), 64'd0);
        check_forwarding({tag, " release"});
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " valid"}, 64'(bus.mem_wb_pipeline_valid), 64'd0);
        check_output({tag, " we"}, 64'(rf_write_enable), 64'd0);
        check_output({tag, " addr"}, 64'(rf_write_addr), 64'd0);
        check_output({tag, " data"}, rf_write_data, 64'd0);
        check_output({tag, " fwd_valid"}, 64'(fwd_valid), 64'd0);
        check_output({tag, " fwd_reg"}, 64'(fwd_reg), 64'd0);
        check_output({tag, " fwd_data"}, fwd_data, 64'd0);
        check_output({tag, " retired"}, retired_count, 64'd0);
    endtask

    vec_t table_v[11];
    vec_t rv;

    initial begin
        checks        = 0;
        errors        = 0;
        exp_retired   = 64'd0;
        exp_fwd_valid = 1'b0;
        exp_fwd_reg   = 5'd0;
        exp_fwd_data  = 64'd0;

        //                loaded                  alu                     pc          dest  rw    m2r   jl    size  uns   expected                 we
        table_v[0]  = '{64'h0000_0000_0000_8000, 64'h0000_0000_0000_0001, 64'h0,      5'd5,  1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b1};
        table_v[1]  = '{64'h8765_4321_0000_0000, 64'h0000_0000_0000_0004, 64'h0,      5'd7,  1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 64'h0000_0000_8765_4321, 1'b1};
        table_v[2]  = '{64'h1111_2222_3333_4444, 64'h0000_0000_0000_0005, 64'h1004,   5'd1,  1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 64'h0000_0000_0000_1004, 1'b1};
        table_v[3]  = '{64'h0000_0000_8001_0000, 64'h0000_0000_0000_0003, 64'h0,      5'd10, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 1'b1};
        table_v[4]  = '{64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0005, 64'h0,      5'd11, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1};
        table_v[5]  = '{64'hFEDC_BA98_7654_3210, 64'h0000_0000_0000_0007, 64'h0,      5'd12, 1'b1, 1'b1, 1'b0, 3'd7, 1'b1, 64'hFEDC_BA98_7654_3210, 1'b1};
        table_v[6]  = '{64'h5555_5555_5555_5555, 64'hDEAD_BEEF_0000_0006, 64'h2000,   5'd31, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'hDEAD_BEEF_0000_0006, 1'b1};
        table_v[7]  = '{64'h0,                   64'h0000_0000_0000_0042, 64'h0,      5'd0,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 64'h0000_0000_0000_0042, 1'b0};
        table_v[8]  = '{64'h0,                   64'h0000_0000_0000_0099, 64'h0,      5'd9,  1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 64'h0000_0000_0000_0099, 1'b0};
        table_v[9]  = '{64'hF000_0000_1234_5678, 64'h0000_0000_0000_0007, 64'h0,      5'd13, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 64'hFFFF_FFFF_F000_0000, 1'b1};
        table_v[10] = '{64'hAB00_0000_0000_0000, 64'h0000_0000_0000_0007, 64'h0,      5'd14, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 64'h0000_0000_0000_00AB, 1'b1};

        bus.memory_done = 1'b0;
        scramble_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        #2 reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(table_v[i], (i == 0) ? 3 : (i % 3), $sformatf("vec%0d", i));
        end

        // Reset arriving mid-HOLD must clear outputs without a clock edge.
        drive_inputs(table_v[1]);
        bus.memory_done = 1'b1;
        @(posedge clk); #1;
        check_output("midhold valid", 64'(bus.mem_wb_pipeline_valid), 64'd1);
        #2 reset = 1'b0;
        #1 check_all_zero("async reset");
        bus.memory_done = 1'b0;
        #1 reset = 1'b1;
        exp_retired   = 64'd0;
        exp_fwd_valid = 1'b0;
        @(posedge clk); #1;
        check_all_zero("post reset");
        apply_stimulus(table_v[3], 1, "after reset");

        // Randomized transactions with random hold lengths and idle gaps.
        for (int n = 0; n < 40; n++) begin
            rv.loaded        = {$urandom, $urandom};
            rv.alu           = {$urandom, $urandom};
            rv.pc            = {$urandom, $urandom};
            rv.dest          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rv.reg_write     = ($urandom_range(0, 5) != 0);
            rv.mem_to_reg    = 1'($urandom);
            rv.jump_link     = ($urandom_range(0, 4) == 0);
            rv.data_size     = 3'($urandom);
            rv.load_unsigned = 1'($urandom);
            rv.exp_data      = ref_wb(rv);
            rv.exp_we        = rv.reg_write && (rv.dest != 5'd0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clk); #1;
                check_output("idle valid", 64'(bus.mem_wb_pipeline_valid), 64'd0);
                check_output("idle we", 64'(rf_write_enable), 64'd0);
            end
            apply_stimulus(rv, int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and writeback stage directly downstream of the memory stage. It captures each completed memory-stage result using the `memory_done` / `mem_wb_pipeline_valid` four-phase handshake, extracts and extends load data, and issues exactly one register-file write per instruction. It also provides a forwarding source for the decode and execute stages and a retired-instruction counter.

## Interface
Parameters:
- `addr_width`, 64: width of the PC and address fields.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `memory_done` in 1: memory stage has a result ready; held high until it sees `mem_wb_pipeline_valid`.
- `loaded_data_in` in 64: raw doubleword returned by the data cache, aligned to an 8-byte boundary.
- `alu_data` in 64: ALU result; bits [2:0] give the load byte offset.
- `pc_plus4` in addr_width: link value for JAL/JALR.
- `dest_reg` in 5: destination register index.
- `reg_write` in 1: instruction writes the register file.
- `mem_to_reg` in 1: writeback source is load data.
- `jump_link` in 1: writeback source is `pc_plus4`; takes priority over `mem_to_reg`.
- `data_size` in 3: load size encoding: 0 = byte, 1 = half, 2 = word; 3 or greater = double.
- `load_unsigned` in 1: zero-extend the load when set; sign-extend when clear.
- `mem_wb_pipeline_valid` out 1: latched result is held; handshake acknowledge to the memory stage.
- `rf_write_enable` out 1: one-cycle register-file write strobe.
- `rf_write_addr` out 5: register-file write index.
- `rf_write_data` out 64: register-file write data.
- `fwd_valid` out 1: forwarding entry is valid.
- `fwd_reg` out 5: forwarding destination register.
- `fwd_data` out 64: forwarding value.
- `retired_count` out 64: number of instructions accepted since reset.

## Operation
- There are two states: IDLE and HOLD.
- IDLE with `memory_done`=1:
  - Latch all inputs.
  - Compute the writeback value.
  - Set `mem_wb_pipeline_valid`=1.
  - Pulse `rf_write_enable` when `reg_write`=1 and `dest_reg`≠0.
  - Increment `retired_count`.
  - Go to HOLD.
- HOLD with `memory_done`=0: clear `mem_wb_pipeline_valid` and go to IDLE.
- HOLD with `memory_done`=1: stay in HOLD. No new capture and no second write occur.
- Writeback value selection:
  - `jump_link` → `pc_plus4`.
  - Otherwise `mem_to_reg` → extracted load.
  - Otherwise `alu_data`.
- Load extraction:
  - Shift `loaded_data_in` right by 8·`alu_data[2:0]`.
  - Take the low 8, 16, 32 or 64 bits according to `data_size`.
  - Extend to 64 bits per `load_unsigned`.
  - Offset bits beyond the natural alignment are ignored: half uses [2:1], word uses [2]; double ignores all offset bits.
- Forwarding:
  - `fwd_valid`=1 from capture until the next capture, when the latched `reg_write`=1 and `dest_reg`≠0.
  - `fwd_reg` and `fwd_data` equal the latched `rf_write_addr` and `rf_write_data`.
- Writes to x0 are suppressed. Such an instruction still completes the handshake and still increments `retired_count`.
- `retired_count` wraps from 2^64−1 to 0.

## Timing
- Reset values: state IDLE; every output 0, including `retired_count`. Reset takes effect asynchronously mid-handshake; any captured-but-unwritten state is discarded.
- Capture latency:
  - Edge E, with `memory_done`=1 in IDLE, is the capture edge.
  - In the cycle after E, `mem_wb_pipeline_valid`=1 and `rf_write_enable`=1. All outputs are registered.
  - `rf_write_enable` is high for exactly one cycle per accepted instruction.
- Release:
  - `mem_wb_pipeline_valid` falls at the first edge in HOLD that samples `memory_done`=0.
  - Minimum spacing is 2 cycles between captures (IDLE→HOLD→IDLE).
- Because `memory_done` is only sampled in IDLE, a `memory_done` that stays high through HOLD is never double-captured.
- `memory_done` rising in the same cycle that `mem_wb_pipeline_valid` falls is sampled at the next edge, in IDLE.
- `fwd_*` changes only on the capture edge or on reset.

## Test plan
- Reset asserted mid-HOLD with `mem_wb_pipeline_valid`=1 → all outputs 0 immediately, without waiting for a clock edge; after release, state is IDLE.
- Load byte, signed, `loaded_data_in`=0x0000_0000_0000_8000, `alu_data[2:0]`=1, `dest_reg`=5 → `rf_write_data`=0xFFFF_FFFF_FFFF_FF80, `rf_write_addr`=5, one-cycle write pulse.
- Load word, unsigned, `loaded_data_in`=0x8765_4321_0000_0000, offset 4 → `rf_write_data`=0x0000_0000_8765_4321.
- JAL with `jump_link`=1, `pc_plus4`=0x1004, `mem_to_reg`=1 → `rf_write_data`=0x1004.
- `memory_done` held high for 4 cycles → exactly one capture, one write and `retired_count`=1; valid falls 1 edge after `memory_done` falls.
- Write to `dest_reg`=0 with `reg_write`=1 → no `rf_write_enable` and `fwd_valid`=0; `retired_count` increments; the handshake completes normally.
